exp_softmax_normalizer: RTL
===========================

// Module: exp_softmax_normalizer
// PURPOSE
//  Downstream stage of the fixed-point exponent unit: collects a vector of VEC_LEN exponent results, accumulates their sum,
//  then emits each element divided by the sum (softmax probability) as unsigned Q1.16. Buffers the vector internally,
//  divides sequentially (one quotient bit per cycle), streams results out over valid/ready.
// PARAMETERS
//  EXP_INT_WIDTH   17   integer bits of exponent input (input range [EXP_INT_WIDTH-1:-EXP_FRAC_WIDTH])
//  EXP_FRAC_WIDTH  28   fraction bits of exponent input
//  VEC_LEN         8    elements per vector (>=1)
//  PROB_FRAC_WIDTH 16   fraction bits of output; output is Q1.PROB_FRAC_WIDTH
// PORTS
//  clk        in   1                 single clock, rising edge
//  rst        in   1                 asynchronous, active-high reset
//  in_valid   in   1                 exponent sample valid
//  in_ready   out  1                 block accepts sample (only in COLLECT)
//  in_data    in   EXP_W=45          unsigned exponent value, Q17.28
//  out_valid  out  1                 probability valid
//  out_ready  in   1                 downstream accepts probability
//  out_data   out  PROB_W=17         unsigned Q1.16 = in_data[i] / sum
//  out_last   out  1                 high with element VEC_LEN-1
//  sum_zero   out  1                 current vector summed to 0; held until next vector's first accept
//  busy       out  1                 high in any state other than COLLECT with idx==0
// BEHAVIOUR
//  - Reset (async): state=COLLECT, idx=0, sum=0, quotient=0; out_valid=0, out_data=0, out_last=0, sum_zero=0,
//    busy=0, in_ready=1 after reset deasserts. Buffer contents undefined. Reset mid-DIV/RESULT aborts vector; no output.
//  - Widths: SUM_W = EXP_W + $clog2(VEC_LEN) (48 default), sum never overflows. Remainder SUM_W+1 bits.
//  - COLLECT: in_ready=1. Transfer = in_valid & in_ready. Each transfer: buf[idx]<=in_data, sum<=sum+in_data, idx++.
//    First transfer of a vector (idx==0) loads sum<=in_data (not accumulate) and clears sum_zero.
//    Transfer with idx==VEC_LEN-1: idx<=0, go DIV.
//  - DIV: in_ready=0. Cycle 0 loads r<=buf[idx], q<=0. Next 17 cycles restoring division:
//    bit 16: q16=(r>=S), r-=S if set; bits 15..0: r<<=1, q_i=(r>=S), r-=S if set. Truncating (no rounding).
//    After iteration 17, go RESULT. Total DIV = 18 cycles; out_valid first rises 19 edges after the last-input edge.
//  - RESULT: out_valid=1, out_data=q, out_last=(idx==VEC_LEN-1); outputs stable until out_ready.
//    On out_valid&out_ready: if out_last -> COLLECT, idx<=0, out_valid<=0; else idx++, -> DIV.
//    out_ready while out_valid=0 is ignored.
//  - Sum zero (all inputs 0, e.g. exponent underflow): sum_zero=1 set on DIV entry; divider bypassed,
//    each element goes DIV(1 cycle)->RESULT with out_data=0; all VEC_LEN outputs still produced.
//  - Input x<=S guarantees q<=2^16 (1.0 = 17'h10000); no saturation required.
//  - in_valid during DIV/RESULT: not accepted, upstream must hold. No simultaneous in/out transfers (strictly phased).
//  - VEC_LEN=1: single element, output 17'h10000 unless sum_zero.
// STRUCTURE
//  - Package exp_pkg: EXP_INT_WIDTH/EXP_FRAC_WIDTH/PROB_FRAC_WIDTH constants, EXP_W/SUM_W/PROB_W localparams,
//    state enum typedef {COLLECT, DIV, RESULT} (2 bits). Shared with the exponent unit for matching widths.
//  - Sub-module seq_divider: restoring divider (start, dividend, divisor, done, quotient), fixed 17+1 cycles.
//  - Top: FSM, idx counter ($clog2(VEC_LEN) bits), sum accumulator, buffer array of VEC_LEN x EXP_W regs.
// TESTING
//  1. 8x in_data=1<<28 (1.0), out_ready=1 -> 8 outputs 17'h02000 (0.125), out_last on 8th, sum_zero=0.
//  2. {3<<28, 1<<28, 6x 0} -> 17'h0C000, 17'h04000, six 0; check out_valid 19 edges after last accept.
//  3. 8x 0 -> sum_zero=1, eight outputs 0, out_last on 8th; next vector with nonzero data clears sum_zero.
//  4. 8x 45'h1FFF_FFFF_FFFF (max) -> all 17'h02000, no accumulator overflow.
//  5. Backpressure: out_ready low 5 cycles on element 2 -> out_data/out_last stable, in_ready=0 throughout, no loss.
//  6. Assert rst during DIV of element 3 -> outputs zero immediately, in_ready=1 after release, next vector correct.

Source files
------------

// File: rtl/exp_pkg.sv
// Shared widths and FSM encoding for the exponent unit and the softmax normalizer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package exp_pkg;

    // Exponent result format: unsigned Q17.28
    localparam int EXP_INT_WIDTH   = 17;
    localparam int EXP_FRAC_WIDTH  = 28;
    // Probability format: unsigned Q1.16
    localparam int PROB_FRAC_WIDTH = 16;

    localparam int EXP_W       = EXP_INT_WIDTH + EXP_FRAC_WIDTH;
    localparam int DEF_VEC_LEN = 8;
    // Accumulator grows by log2(VEC_LEN) bits so the vector sum can never wrap
    localparam int SUM_W       = EXP_W + $clog2(DEF_VEC_LEN);
    localparam int PROB_W      = PROB_FRAC_WIDTH + 1;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DIV     = 2'd1,
        RESULT  = 2'd2
    } state_t;

    // Index counters need at least one bit even for single-element vectors
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider producing a Q_W-bit quotient of dividend/divisor (dividend <= divisor), one bit per cycle.
// Latency: one load cycle (start) then Q_W iteration cycles; done rises after the last iteration and holds until next start.
// Backpressure: none; the caller keeps dividend/divisor stable and reads quotient while done is high.
module seq_divider #(
    parameter int DVD_W = 45,
    parameter int DVS_W = 48,
    parameter int Q_W   = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             done,
    output logic [Q_W-1:0]   quotient
);

    // One extra remainder bit absorbs the left shift before the compare
    localparam int R_W   = DVS_W + 1;
    localparam int CNT_W = $clog2(Q_W);

    logic [R_W-1:0]   rem;
    logic [R_W-1:0]   trial;
    logic [R_W-1:0]   divisor_ext;
    logic [CNT_W-1:0] cnt;
    logic             running;
    logic             ge;

    // Trial remainder: the integer bit uses the dividend as-is, every fraction bit shifts first
    always_comb begin
        divisor_ext = R_W'(divisor);
        trial       = (cnt == '0) ? rem : {rem[R_W-2:0], 1'b0};
        ge          = (trial >= divisor_ext);
    end

    // Load on start, then retire one quotient bit per cycle (truncating)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem      <= '0;
            quotient <= '0;
            cnt      <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
        end else if (start) begin
            rem      <= R_W'(dividend);
            quotient <= '0;
            cnt      <= '0;
            running  <= 1'b1;
            done     <= 1'b0;
        end else if (running) begin
            rem      <= ge ? (trial - divisor_ext) : trial;
            quotient <= {quotient[Q_W-2:0], ge};
            if (cnt == CNT_W'(Q_W - 1)) begin
                running <= 1'b0;
                done    <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/exp_softmax_normalizer.sv
// Buffers VEC_LEN exponent results, sums them, then streams each element / sum as unsigned Q1.16.
// Latency: out_valid rises 19 edges after the last input accept (1 edge for an all-zero vector), 19 edges between elements.
// Backpressure: in_ready only in COLLECT; each result is held stable until out_ready, input and output phases never overlap.
module exp_softmax_normalizer
    import exp_pkg::*;
#(
    parameter int VEC_LEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [EXP_W-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROB_W-1:0] out_data,
    output logic              out_last,
    output logic              sum_zero,
    output logic              busy
);

    localparam int IDX_W = idx_width(VEC_LEN);
    localparam int SUM_L = EXP_W + $clog2(VEC_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [SUM_L-1:0]   sum;
    logic [SUM_L-1:0]   sum_add;
    logic [EXP_W-1:0]   vbuf [VEC_LEN];
    logic               div_launched;
    logic               div_start;
    logic               div_done;
    logic [PROB_W-1:0]  quotient;
    logic               in_xfer;
    logic               out_xfer;
    logic               idx_is_last;

    assign in_ready    = (state == COLLECT);
    assign busy        = !((state == COLLECT) && (idx == '0));
    assign in_xfer     = in_valid && in_ready;
    assign out_xfer    = out_valid && out_ready;
    assign idx_is_last = (idx == LAST_IDX);
    // The first element of a vector restarts the sum rather than accumulating
    assign sum_add     = (idx == '0) ? SUM_L'(in_data) : (sum + SUM_L'(in_data));
    // A zero sum skips the divider entirely
    assign div_start   = (state == DIV) && !div_launched && !sum_zero;

    seq_divider #(
        .DVD_W (EXP_W),
        .DVS_W (SUM_L),
        .Q_W   (PROB_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (vbuf[idx]),
        .divisor  (sum),
        .done     (div_done),
        .quotient (quotient)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: collect a full vector, then alternate divide/present per element
    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: begin
                if (in_xfer && idx_is_last) begin
                    state_nxt = DIV;
                end
            end
            DIV: begin
                // div_launched masks the stale done left over from the previous element
                if (sum_zero || (div_launched && div_done)) begin
                    state_nxt = RESULT;
                end
            end
            RESULT: begin
                if (out_xfer) begin
                    state_nxt = out_last ? COLLECT : DIV;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    // Vector storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            vbuf[idx] <= in_data;
        end
    end

    // Index, accumulator, zero-sum flag and the registered output stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx          <= '0;
            sum          <= '0;
            sum_zero     <= 1'b0;
            div_launched <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_last     <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (in_xfer) begin
                        sum <= sum_add;
                        if (idx_is_last) begin
                            idx      <= '0;
                            sum_zero <= (sum_add == '0);
                        end else begin
                            idx <= idx + IDX_W'(1);
                            if (idx == '0) begin
                                sum_zero <= 1'b0;
                            end
                        end
                    end
                end
                DIV: begin
                    if (div_start) begin
                        div_launched <= 1'b1;
                    end
                    if (state_nxt == RESULT) begin
                        div_launched <= 1'b0;
                        out_valid    <= 1'b1;
                        out_data     <= sum_zero ? '0 : quotient;
                        out_last     <= idx_is_last;
                    end
                end
                RESULT: begin
                    if (out_xfer) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        idx       <= out_last ? '0 : (idx + IDX_W'(1));
                    end
                end
                default: begin
                    idx <= '0;
                end
            endcase
        end
    end

endmodule
